cpu_sequencer: RTL and testbench

// Multi-cycle fetch/decode/execute sequencer for the 18-bit CPU. Loads the instruction register,

---
 rtl/cpu_sequencer_if.sv | 44 ++++
 rtl/cpu_sequencer.sv | 157 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Decoder/memory-side bundle of the CPU sequencer.
// Carries raw decoder strobes and the instruction word in, gated strobes and status out.
interface cpu_sequencer_if #(
  parameter int INSTR_W = 18
);
  logic               run;
  logic [INSTR_W-1:0] mem_rdata;
  logic               halt_req;
  logic               dec_is_mul;
  logic               dec_mem_access;
  logic               dec_we1;
  logic               dec_we2;
  logic               dec_flagwrite;
  logic               dec_memwrite;
  logic               dec_pc_load;

  logic [INSTR_W-1:0] instr_out;
  logic               fetch_en;
  logic               ir_load;
  logic               pc_inc;
  logic               we1;
  logic               we2;
  logic               flag_we;
  logic               mem_we;
  logic               pc_we;
  logic               busy;
  logic               halted;
  logic [31:0]        instr_retired;

  // Decoder/environment side drives the raw strobes and observes the gated ones.
  modport master (
    output run, mem_rdata, halt_req, dec_is_mul, dec_mem_access,
           dec_we1, dec_we2, dec_flagwrite, dec_memwrite, dec_pc_load,
    input  instr_out, fetch_en, ir_load, pc_inc, we1, we2, flag_we,
           mem_we, pc_we, busy, halted, instr_retired
  );

  modport slave (
    input  run, mem_rdata, halt_req, dec_is_mul, dec_mem_access,
           dec_we1, dec_we2, dec_flagwrite, dec_memwrite, dec_pc_load,
    output instr_out, fetch_en, ir_load, pc_inc, we1, we2, flag_we,
           mem_we, pc_we, busy, halted, instr_retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 18-bit CPU.
// Define SEQ_INSTR_COUNT_EN to enable the retired-instruction counter on instr_retired.
module cpu_sequencer #(
  parameter int INSTR_W    = 18,
  parameter int MEM_LAT    = 1,
  parameter int MUL_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    MULW   = 3'd5,
    HALT   = 3'd6
  } state_e;

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  logic retire;
  logic fetch_en, ir_load, pc_inc;
  logic we1, we2, flag_we, mem_we, pc_we;

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    fetch_en = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    we1      = 1'b0;
    we2      = 1'b0;
    flag_we  = 1'b0;
    mem_we   = 1'b0;
    pc_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        fetch_en = 1'b1;
        if (cnt_q == MEM_LAST) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (bus.halt_req)            state_d = HALT;
        else if (bus.dec_is_mul)     state_d = MULW;
        else if (bus.dec_mem_access) state_d = MEM;
        else                         state_d = EXEC;
      end
      EXEC: begin
        we1     = bus.dec_we1;
        we2     = bus.dec_we2;
        flag_we = bus.dec_flagwrite;
        pc_we   = bus.dec_pc_load;
        retire  = 1'b1;
      end
      // Store data goes out on the first cycle; load results land on the last.
      MEM: begin
        if (cnt_q == 4'd0) mem_we = bus.dec_memwrite;
        if (cnt_q == MEM_LAST) begin
          we1    = bus.dec_we1;
          we2    = bus.dec_we2;
          pc_we  = bus.dec_pc_load;
          retire = 1'b1;
        end
      end
      MULW: begin
        if (cnt_q == MUL_LAST) begin
          we1     = bus.dec_we1;
          we2     = bus.dec_we2;
          flag_we = bus.dec_flagwrite;
          retire  = 1'b1;
        end
      end
      HALT: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // run is only looked at on instruction boundaries.
    if (retire) state_d = bus.run ? FETCH : IDLE;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 4'd0;
    end else if ((state_q == FETCH || state_q == MEM || state_q == MULW) &&
                 cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    instr_d = instr_q;
    if (ir_load) instr_d = bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  assign bus.instr_out = instr_q;
  assign bus.fetch_en  = fetch_en;
  assign bus.ir_load   = ir_load;
  assign bus.pc_inc    = pc_inc;
  assign bus.we1       = we1;
  assign bus.we2       = we2;
  assign bus.flag_we   = flag_we;
  assign bus.mem_we    = mem_we;
  assign bus.pc_we     = pc_we;
  assign bus.busy      = (state_q != IDLE) && (state_q != HALT);
  assign bus.halted    = (state_q == HALT);

`ifdef SEQ_INSTR_COUNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= 32'd0;
    else       retired_q <= retired_d;
  end

  assign bus.instr_retired = retired_q;
`else
  assign bus.instr_retired = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: two instances (MEM_LAT=1/MUL=4 and MEM_LAT=2/MUL=3)
// share stimulus and are compared every cycle against an instruction-timeline model.
module tb_cpu_sequencer;

  localparam int LAT_A = 1;
  localparam int MUL_A = 4;
  localparam int LAT_B = 2;
  localparam int MUL_B = 3;

  localparam int K_EXEC = 0;
  localparam int K_MEM  = 1;
  localparam int K_MUL  = 2;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_HALT = 2;

  // One model record per instance: where we are in the current instruction's timeline.
  typedef struct {
    int          mode;
    int          t;
    int          kind;
    logic [17:0] instr;
    logic [31:0] ret;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        haltReq = 1'b0;
  logic        decIsMul = 1'b0;
  logic        decMemAccess = 1'b0;
  logic        decWe1 = 1'b0;
  logic        decWe2 = 1'b0;
  logic        decFlagWrite = 1'b0;
  logic        decMemWrite = 1'b0;
  logic        decPcLoad = 1'b0;
  logic [17:0] memRdata = '0;

  int   checks = 0;
  int   fails = 0;
  mdl_t mA, mB;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.INSTR_W(18)) busA ();
  cpu_sequencer_if #(.INSTR_W(18)) busB ();

  assign busA.run = run;             assign busB.run = run;
  assign busA.mem_rdata = memRdata;  assign busB.mem_rdata = memRdata;
  assign busA.halt_req = haltReq;    assign busB.halt_req = haltReq;
  assign busA.dec_is_mul = decIsMul; assign busB.dec_is_mul = decIsMul;
  assign busA.dec_mem_access = decMemAccess;
  assign busB.dec_mem_access = decMemAccess;
  assign busA.dec_we1 = decWe1;      assign busB.dec_we1 = decWe1;
  assign busA.dec_we2 = decWe2;      assign busB.dec_we2 = decWe2;
  assign busA.dec_flagwrite = decFlagWrite;
  assign busB.dec_flagwrite = decFlagWrite;
  assign busA.dec_memwrite = decMemWrite;
  assign busB.dec_memwrite = decMemWrite;
  assign busA.dec_pc_load = decPcLoad;
  assign busB.dec_pc_load = decPcLoad;

  cpu_sequencer #(.INSTR_W(18), .MEM_LAT(LAT_A), .MUL_CYCLES(MUL_A)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  cpu_sequencer #(.INSTR_W(18), .MEM_LAT(LAT_B), .MUL_CYCLES(MUL_B)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  function automatic int exec_len(int kind, int lat, int mul);
    if (kind == K_MUL) return mul;
    if (kind == K_MEM) return lat;
    return 1;
  endfunction

  // Strobe order: fetch_en ir_load pc_inc we1 we2 flag_we mem_we pc_we busy halted
  function automatic logic [9:0] exp_strobes(mdl_t m, int lat, int mul);
    logic fe, irl, pci, w1, w2, fw, mw, pw;
    int   e, n;
    {fe, irl, pci, w1, w2, fw, mw, pw} = 8'd0;
    if (m.mode == M_HALT) return 10'b00000_00001;
    if (m.mode == M_IDLE) return 10'd0;
    if (m.t < lat) begin
      fe  = 1'b1;
      irl = (m.t == lat - 1);
      pci = irl;
    end else if (m.t > lat) begin
      e = m.t - lat - 1;
      n = exec_len(m.kind, lat, mul);
      if (m.kind == K_EXEC) begin
        {w1, w2, fw, pw} = {decWe1, decWe2, decFlagWrite, decPcLoad};
      end else if (m.kind == K_MEM) begin
        if (e == 0) mw = decMemWrite;
        if (e == n - 1) {w1, w2, pw} = {decWe1, decWe2, decPcLoad};
      end else begin
        if (e == n - 1) {w1, w2, fw} = {decWe1, decWe2, decFlagWrite};
      end
    end
    return {fe, irl, pci, w1, w2, fw, mw, pw, 1'b1, 1'b0};
  endfunction

  function automatic logic [59:0] exp_all(mdl_t m, int lat, int mul);
    return {exp_strobes(m, lat, mul), m.instr, m.ret};
  endfunction

  function automatic mdl_t advance(mdl_t m, int lat, int mul);
    mdl_t r;
    r = m;
    if (reset) begin
      r.mode  = M_IDLE;
      r.t     = 0;
      r.kind  = K_EXEC;
      r.instr = '0;
      r.ret   = '0;
      return r;
    end
    if (m.mode == M_IDLE) begin
      if (run) begin
        r.mode = M_BUSY;
        r.t    = 0;
      end
    end else if (m.mode == M_BUSY) begin
      if (m.t == lat - 1) r.instr = memRdata;
      if (m.t == lat) begin
        if (haltReq) begin
          r.mode = M_HALT;
          return r;
        end
        r.kind = decIsMul ? K_MUL : (decMemAccess ? K_MEM : K_EXEC);
      end
      if (m.t > lat && (m.t - lat) == exec_len(m.kind, lat, mul)) begin
`ifdef SEQ_INSTR_COUNT_EN
        r.ret = m.ret + 32'd1;
`endif
        r.mode = run ? M_BUSY : M_IDLE;
        r.t    = 0;
      end else begin
        r.t = m.t + 1;
      end
    end
    return r;
  endfunction

  function automatic logic [59:0] obs_a();
    return {busA.fetch_en, busA.ir_load, busA.pc_inc, busA.we1, busA.we2,
            busA.flag_we, busA.mem_we, busA.pc_we, busA.busy, busA.halted,
            busA.instr_out, busA.instr_retired};
  endfunction

  function automatic logic [59:0] obs_b();
    return {busB.fetch_en, busB.ir_load, busB.pc_inc, busB.we1, busB.we2,
            busB.flag_we, busB.mem_we, busB.pc_we, busB.busy, busB.halted,
            busB.instr_out, busB.instr_retired};
  endfunction

  task automatic tick();
    @(posedge clk);
    mA = advance(mA, LAT_A, MUL_A);
    mB = advance(mB, LAT_B, MUL_B);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic h, input logic mu, input logic ma,
                       input logic w1, input logic w2, input logic fw,
                       input logic mw, input logic pl);
    run          = r;
    haltReq      = h;
    decIsMul     = mu;
    decMemAccess = ma;
    decWe1       = w1;
    decWe2       = w2;
    decFlagWrite = fw;
    decMemWrite  = mw;
    decPcLoad    = pl;
    memRdata     = 18'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [119:0] got, exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 1, 1, 1, 1);
      #1;
      got = {obs_a(), obs_b()};
      exp = {exp_all(mA, LAT_A, MUL_A), exp_all(mB, LAT_B, MUL_B)};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL reset cyc%0d got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_add();
    logic [119:0] got, exp;
    int we1Count = 0;
    int flagCount = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 1, 0, 1, 0, 0);
      #1;
      got = {obs_a(), obs_b()};
      exp = {exp_all(mA, LAT_A, MUL_A), exp_all(mB, LAT_B, MUL_B)};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL add cyc%0d got=%h exp=%h", i, got, exp);
      end
      if (busA.we1 === 1'b1) we1Count++;
      if (busA.flag_we === 1'b1) flagCount++;
      tick();
    end
    checks++;
    if (we1Count != 3 || flagCount != 3) begin
      fails++;
      $display("[TB] FAIL add_pulses we1=%0d flag=%0d expected 3 each", we1Count, flagCount);
    end
  endtask

  task automatic test_mul();
    logic [119:0] got, exp;
    int we1Count = 0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
      #1;
      got = {obs_a(), obs_b()};
      exp = {exp_all(mA, LAT_A, MUL_A), exp_all(mB, LAT_B, MUL_B)};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL mul cyc%0d got=%h exp=%h", i, got, exp);
      end
      if (busA.we1 === 1'b1) we1Count++;
      tick();
    end
    checks++;
    if (we1Count != 2) begin
      fails++;
      $display("[TB] FAIL mul_pulses we1=%0d expected 2", we1Count);
    end
  endtask

  task automatic test_store();
    logic [119:0] got, exp;
    int memWeCount = 0;
    int fetchCount = 0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(1, 0, 0, 1, 0, 0, 0, 1, 0);
      #1;
      got = {obs_a(), obs_b()};
      exp = {exp_all(mA, LAT_A, MUL_A), exp_all(mB, LAT_B, MUL_B)};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL store cyc%0d got=%h exp=%h", i, got, exp);
      end
      if (busB.mem_we === 1'b1) memWeCount++;
      if (busB.fetch_en === 1'b1) fetchCount++;
      tick();
    end
    checks++;
    if (memWeCount != 2 || fetchCount != 4) begin
      fails++;
      $display("[TB] FAIL store_pulses mem_we=%0d fetch_en=%0d expected 2 and 4",
               memWeCount, fetchCount);
    end
  endtask

  task automatic test_halt();
    logic [119:0] got, exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive((i % 2) == 0, 1, 0, 0, 1, 1, 1, 1, 1);
      #1;
      got = {obs_a(), obs_b()};
      exp = {exp_all(mA, LAT_A, MUL_A), exp_all(mB, LAT_B, MUL_B)};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL halt cyc%0d got=%h exp=%h", i, got, exp);
      end
      tick();
    end
    #1;
    checks++;
    if ({busA.halted, busA.busy, busB.halted, busB.busy} !== 4'b1010) begin
      fails++;
      $display("[TB] FAIL halt_sticky got=%b expected 1010",
               {busA.halted, busA.busy, busB.halted, busB.busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [119:0] got, exp;
    int we1Count = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i < 5, 0, 1, 0, 1, 0, 0, 0, 0);
      reset = (i == 4);
      #1;
      got = {obs_a(), obs_b()};
      exp = {exp_all(mA, LAT_A, MUL_A), exp_all(mB, LAT_B, MUL_B)};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL reset_mid cyc%0d got=%h exp=%h", i, got, exp);
      end
      if (busA.we1 === 1'b1) we1Count++;
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (we1Count != 0 || busA.instr_out !== 18'd0 || busA.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_state we1=%0d instr=%h busy=%b expected 0/0/0",
               we1Count, busA.instr_out, busA.busy);
    end
  endtask

  task automatic test_run_drop();
    logic [119:0] got, exp;
    logic [31:0]  expRet;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(i < 9, 0, 0, 0, 1, 1, 0, 0, 0);
      #1;
      got = {obs_a(), obs_b()};
      exp = {exp_all(mA, LAT_A, MUL_A), exp_all(mB, LAT_B, MUL_B)};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL run_drop cyc%0d got=%h exp=%h", i, got, exp);
      end
      tick();
    end
`ifdef SEQ_INSTR_COUNT_EN
    expRet = 32'd3;
`else
    expRet = 32'd0;
`endif
    #1;
    checks++;
    if (busA.instr_retired !== expRet || busA.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL run_drop_retired got=%0d busy=%b expected %0d busy=0",
               busA.instr_retired, busA.busy, expRet);
    end
  endtask

  task automatic test_random();
    logic [119:0] got, exp;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      reset = ($urandom_range(0, 79) == 0);
      #1;
      got = {obs_a(), obs_b()};
      exp = {exp_all(mA, LAT_A, MUL_A), exp_all(mB, LAT_B, MUL_B)};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL random cyc%0d got=%h exp=%h", i, got, exp);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_mul();
    test_store();
    test_halt();
    test_reset_mid();
    test_run_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
